// File: rtl/pr_chk_pkg.sv
// Shared types and constants for the partial-reconfiguration stream checker.
// Optional error counter is built only when PR_CHK_ERR_CNT_EN is defined.
package pr_chk_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } pr_chk_state_e;

    localparam int                   ERR_CNT_W   = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

    // Bits needed to hold the value max_val (at least one).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((64'd1 << w) <= 64'(max_val)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pr_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Used for the run, miss and error counters of the stream checker.
module pr_chk_sat_cnt #(
    parameter int         W   = 4,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Counter state: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != MAX)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pr_stream_checker.sv
// Registers the reconfigurable module's sample stream and checks it against prev + STEP.
// Define PR_CHK_ERR_CNT_EN to build the 16-bit saturating err_count register.
module pr_stream_checker
    import pr_chk_pkg::*;
#(
    parameter int W      = 16,
    parameter int STEP   = 1,
    parameter int LOCK_N = 8,
    parameter int MISS_N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 decouple,
    input  logic [W-1:0]         data_in,
    output logic [W-1:0]         data_out,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 trig
);

    localparam int              RUN_W     = cnt_width(LOCK_N);
    localparam int              MISS_W    = cnt_width(MISS_N);
    localparam logic [W-1:0]    STEP_V    = W'(STEP);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_N);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_N);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_N - 1);

    pr_chk_state_e     state_r;
    pr_chk_state_e     state_nx_s;
    logic [W-1:0]      prev_r;
    logic [W-1:0]      data_out_r;
    logic              locked_r;
    logic              err_pulse_r;
    logic              trig_r;

    logic [W-1:0]      expect_s;
    logic              match_s;
    logic              run_done_s;
    logic              miss_hit_s;
    logic [RUN_W-1:0]  run_cnt_s;
    logic [MISS_W-1:0] miss_cnt_s;
    logic              run_clr_s;
    logic              run_inc_s;
    logic              miss_clr_s;
    logic              miss_inc_s;
    logic              err_s;
    logic              trig_s;

    assign expect_s   = prev_r + STEP_V;
    assign match_s    = (data_in == expect_s);
    assign run_done_s = (state_r == ST_ACQUIRE) && (run_cnt_s == RUN_MAX);
    // Loss of lock is decided on the MISS_N-th bad sample itself, so no extra pulse follows.
    assign miss_hit_s = (state_r == ST_LOCKED) && !match_s && (miss_cnt_s == MISS_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; decouple overrides every other transition.
    always_comb begin
        state_nx_s = state_r;
        if (decouple) begin
            state_nx_s = ST_HOLD;
        end else begin
            case (state_r)
                ST_HOLD:    state_nx_s = ST_ACQUIRE;
                ST_ACQUIRE: state_nx_s = run_done_s ? ST_LOCKED : ST_ACQUIRE;
                ST_LOCKED:  state_nx_s = miss_hit_s ? ST_ACQUIRE : ST_LOCKED;
                default:    state_nx_s = ST_HOLD;
            endcase
        end
    end

    // Counter controls and per-sample flags for the current state.
    always_comb begin
        run_clr_s  = 1'b1;
        run_inc_s  = 1'b0;
        miss_clr_s = 1'b1;
        miss_inc_s = 1'b0;
        err_s      = 1'b0;
        trig_s     = 1'b0;
        case (state_r)
            ST_ACQUIRE: begin
                run_clr_s = decouple || !match_s;
                run_inc_s = match_s;
            end
            ST_LOCKED: begin
                err_s      = !match_s;
                miss_inc_s = !match_s;
                miss_clr_s = match_s || miss_hit_s || decouple;
                trig_s     = miss_hit_s && !decouple;
            end
            ST_HOLD: begin
                run_clr_s  = 1'b1;
                miss_clr_s = 1'b1;
            end
            default: begin
                run_clr_s  = 1'b1;
                miss_clr_s = 1'b1;
            end
        endcase
    end

    pr_chk_sat_cnt #(.W(RUN_W), .MAX(RUN_MAX)) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_clr_s),
        .inc   (run_inc_s),
        .count (run_cnt_s)
    );

    pr_chk_sat_cnt #(.W(MISS_W), .MAX(MISS_MAX)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (miss_clr_s),
        .inc   (miss_inc_s),
        .count (miss_cnt_s)
    );

    // Sample history and registered outputs; data_out freezes while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r      <= {W{1'b0}};
            data_out_r  <= {W{1'b0}};
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            trig_r      <= 1'b0;
        end else begin
            if ((state_r != ST_HOLD) || !decouple) begin
                prev_r <= data_in;
            end else begin
                prev_r <= prev_r;
            end
            if (state_r != ST_HOLD) begin
                data_out_r <= data_in;
            end else begin
                data_out_r <= data_out_r;
            end
            locked_r    <= (state_nx_s == ST_LOCKED);
            err_pulse_r <= err_s;
            trig_r      <= trig_s;
        end
    end

`ifdef PR_CHK_ERR_CNT_EN
    pr_chk_sat_cnt #(.W(ERR_CNT_W), .MAX(ERR_CNT_MAX)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (err_s),
        .count (err_count)
    );
`else
    assign err_count = {ERR_CNT_W{1'b0}};
`endif

    assign data_out  = data_out_r;
    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign trig      = trig_r;

endmodule

// File: tb/tb_pr_stream_checker.sv
// Randomized and directed bench for pr_stream_checker with a behavioural reference model.
// Honours PR_CHK_ERR_CNT_EN: err_count is modelled when defined, expected 0 otherwise.
module tb_pr_stream_checker;

    localparam int W      = 16;
    localparam int STEP   = 1;
    localparam int LOCK_N = 8;
`ifdef PR_CHK_ERR_CNT_EN
    localparam int MISS_N = 256;
`else
    localparam int MISS_N = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          decouple;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          locked;
    logic          err_pulse;
    logic [15:0]   err_count;
    logic          trig;

    always #5 clk = ~clk;

    pr_stream_checker #(.W(W), .STEP(STEP), .LOCK_N(LOCK_N), .MISS_N(MISS_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .decouple  (decouple),
        .data_in   (data_in),
        .data_out  (data_out),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .trig      (trig)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int trig_seen = 0;

    // Reference model state
    bit          m_hold, m_locked, m_err, m_trig;
    int          m_run, m_miss, m_cnt;
    logic [15:0] m_prev, m_dout;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b1; m_locked = 1'b0; m_err = 1'b0; m_trig = 1'b0;
        m_run = 0; m_miss = 0; m_cnt = 0;
        m_prev = 16'h0000; m_dout = 16'h0000;
    endtask

    function automatic logic [31:0] exp_count();
`ifdef PR_CHK_ERR_CNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // One clock edge of the checker as described by its rules.
    task automatic model_edge(input bit d, input logic [15:0] x);
        bit match;
        m_err  = 1'b0;
        m_trig = 1'b0;
        if (m_hold) begin
            if (!d) begin
                m_hold = 1'b0;
                m_prev = x;
                m_run  = 0;
            end
        end else begin
            match  = (x == 16'(m_prev + 16'(STEP)));
            m_dout = x;
            if (m_locked) begin
                if (!match) begin
                    m_err = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                    m_miss++;
                end else begin
                    m_miss = 0;
                end
                if (m_miss == MISS_N) begin
                    m_locked = 1'b0; m_trig = 1'b1; m_run = 0; m_miss = 0;
                end
            end else begin
                if (m_run >= LOCK_N) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end else begin
                    m_run = match ? m_run + 1 : 0;
                end
            end
            m_prev = x;
            if (d) begin
                m_hold = 1'b1; m_locked = 1'b0; m_run = 0; m_miss = 0; m_trig = 1'b0;
            end
        end
    endtask

    task automatic step(input bit d, input logic [15:0] x);
        @(negedge clk);
        decouple = d;
        data_in  = x;
        @(posedge clk);
        model_edge(d, x);
        #1;
        check("data_out",  32'(data_out),  32'(m_dout));
        check("locked",    32'(locked),    32'(m_locked));
        check("err_pulse", 32'(err_pulse), 32'(m_err));
        check("trig",      32'(trig),      32'(m_trig));
        check("err_count", 32'(err_count), exp_count());
        err_seen  += int'(err_pulse);
        trig_seen += int'(trig);
    endtask

    task automatic run_counter(input logic [15:0] start, input int n, output int lock_edge);
        lock_edge = -1;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 16'(start + 16'(i)));
            if (locked && lock_edge < 0) lock_edge = i + 1;
        end
    endtask

    initial begin
        int          le;
        logic [15:0] cur;
        logic [15:0] frozen;
        logic [15:0] cnt_before;
        bit          dec;
        int          r;

        rst_n = 1'b0; decouple = 1'b1; data_in = 16'h0000;
        model_reset();
        #12;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_err",      32'(err_pulse), 32'd0);
        check("rst_count",    32'(err_count), 32'd0);
        check("rst_trig",     32'(trig),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire from a clean counter stream
        run_counter(16'h0000, 20, le);
        check("lock_latency", 32'(le), 32'd10);

        // Wrap-around while locked
        step(1'b1, 16'd20);
        err_seen = 0;
        run_counter(16'hFFF0, 24, le);
        check("wrap_lock_latency", 32'(le), 32'd10);
        check("wrap_err", 32'(err_seen), 32'd0);
        check("wrap_locked", 32'(locked), 32'd1);

        // Single corrupted sample gives two error pulses
        err_seen = 0; trig_seen = 0;
        for (int v = 8; v <= 16'h50; v++) begin
            step(1'b0, (v == 16'h40) ? 16'h1234 : 16'(v));
        end
        check("bad_err", 32'(err_seen), 32'd2);
        check("bad_trig", 32'(trig_seen), 32'd0);
        check("bad_locked", 32'(locked), 32'd1);
`ifdef PR_CHK_ERR_CNT_EN
        check("bad_count", 32'(err_count), 32'd2);
`else
        check("bad_count", 32'(err_count), 32'd0);
`endif

        // Stuck stream loses lock and never regains it
        err_seen = 0; trig_seen = 0;
        for (int i = 0; i < MISS_N + 12; i++) step(1'b0, 16'h5555);
        check("stuck_err", 32'(err_seen), 32'(MISS_N));
        check("stuck_trig", 32'(trig_seen), 32'd1);
        check("stuck_locked", 32'(locked), 32'd0);

        // Decoupled window with garbage, then a new module's stream
        run_counter(16'h0100, 20, le);
        step(1'b1, 16'h0114);
        frozen = data_out; cnt_before = err_count;
        err_seen = 0; trig_seen = 0;
        for (int i = 0; i < 19; i++) step(1'b1, 16'($urandom));
        check("dec_frozen", 32'(data_out), 32'(frozen));
        check("dec_err", 32'(err_seen), 32'd0);
        check("dec_trig", 32'(trig_seen), 32'd0);
        check("dec_count", 32'(err_count), 32'(cnt_before));
        run_counter(16'h8000, 16, le);
        check("relock_latency", 32'(le), 32'd10);

        // Mismatch coinciding with decouple is still reported
        step(1'b1, 16'hDEAD);
        check("dec_mismatch_err", 32'(err_pulse), 32'd1);
        check("dec_mismatch_locked", 32'(locked), 32'd0);

        // Randomized mix of good, bad, repeated samples and decouple episodes
        cur = 16'($urandom); dec = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) dec = ~dec;
            r = int'($urandom_range(0, 99));
            if (r < 90)      cur = cur + 16'd1;
            else if (r < 95) cur = 16'($urandom);
            step(dec, cur);
        end

        // Asynchronous reset mid-operation
        run_counter(16'h2000, 20, le);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_data_out", 32'(data_out), 32'd0);
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_counter(16'h0000, 12, le);
        check("arst_relock", 32'(le), 32'd10);

`ifdef PR_CHK_ERR_CNT_EN
        // Drive the error counter to saturation while staying locked
        cur = 16'd11;
        while (m_cnt < 16'hFFFE) begin
            for (int k = 0; k < MISS_N - 1 && m_cnt < 16'hFFFE; k++) begin
                cur = cur + 16'd2;
                step(1'b0, cur);
            end
            cur = cur + 16'd1;
            step(1'b0, cur);
        end
        check("sat_pre", 32'(err_count), 32'hFFFE);
        check("sat_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 2; k++) begin
            cur = cur + 16'd2;
            step(1'b0, cur);
        end
        check("sat_full", 32'(err_count), 32'hFFFF);
        cur = cur + 16'd1; step(1'b0, cur);
        cur = cur + 16'd2; step(1'b0, cur);
        check("sat_nowrap", 32'(err_count), 32'hFFFF);
`else
        check("cnt_disabled", 32'(err_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
